register_file_dumper: RTL

// - Read-side sequencer for register_file. On a start pulse it walks every register address in order and reads each one.
// - Streams each value out on a valid/ready port, tagged with its index, for debug readout or a scan-out to the host.
// - Sits beside register_file and shares its address/control pins through a mux owned by the top level.

---
 rtl/register_file_dumper.sv | 121 ++++++++++++
 1 files changed

// File: rtl/register_file_dumper.sv
// Read-side sequencer that walks every register_file address and streams each value out on a valid/ready port.
// Optional checksum word enabled by defining REGISTER_FILE_DUMPER_CHECKSUM_EN.
module register_file_dumper #(
  parameter int pointer_width = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [pointer_width-1:0] rf_address,
  output logic                     rf_write_enable,
  output logic                     rf_is_immediate,
  input  logic [7:0]               rf_data_out,
  output logic [7:0]               out_data,
  output logic [pointer_width-1:0] out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam logic [pointer_width-1:0] LAST_INDEX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                   state;
  logic [pointer_width-1:0] index;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
  logic [7:0]               sum;
`endif

  // The dumper only ever reads, in register mode.
  assign rf_write_enable = 1'b0;
  assign rf_is_immediate = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      rf_address <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            index      <= '0;
            rf_address <= '0;
            busy       <= 1'b1;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        FETCH: begin
          out_data  <= rf_data_out;
          out_index <= index;
          out_valid <= 1'b1;
          state     <= SEND;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
          out_last  <= 1'b0;
          sum       <= sum + rf_data_out;
`else
          out_last  <= (index == LAST_INDEX);
`endif
        end
        SEND: begin
          // Word is held untouched until the sink takes it.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
            else if (index == LAST_INDEX) begin
              state <= CHECK;
            end
`endif
            else begin
              index      <= index + 1'b1;
              rf_address <= index + 1'b1;
              state      <= FETCH;
            end
          end
        end
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
        CHECK: begin
          out_data  <= sum;
          out_index <= '0;
          out_last  <= 1'b1;
          out_valid <= 1'b1;
          state     <= SEND;
        end
`endif
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          rf_address <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
